// File: rtl/fetch_decode_queue_pkg.sv
// Shared core definitions for the fetch/decode boundary: PC width, the
// {pc, instr} entry layout and the canonical NOP encoding.
package fetch_decode_queue_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;

    typedef logic [XLEN-1:0] t_xlen;

    typedef struct packed {
        t_xlen              pc;
        logic [INSTR_W-1:0] instr;
    } t_fetch_entry;

    // addi x0, x0, 0 -- available to decode for bubble insertion
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    // A fetched PC is misaligned when it is not on a 4-byte boundary
    function automatic logic pc_misaligned(input t_xlen pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_decode_queue_if.sv
// Fetch-side and decode-side handshake bundle of the fetch/decode queue.
// master: the environment (fetch + decode); slave: the queue itself.
interface fetch_decode_queue_if #(
    parameter int unsigned DEPTH = 4
) ();
    import fetch_decode_queue_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    // fetch side
    logic               in_valid;
    logic               in_ready;
    t_xlen              in_pc;
    logic [INSTR_W-1:0] in_instr;

    // decode side
    logic               out_valid;
    logic               out_ready;
    t_xlen              out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic               out_misaligned;

    // occupancy
    logic [CW-1:0]      count;

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_misaligned, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_misaligned, count
    );

endinterface

// File: rtl/fetch_decode_queue_storage.sv
// fdq_storage: DEPTH x t_fetch_entry register array with synchronous write,
// asynchronous read and synchronous clear of every entry.
module fdq_storage
    import fetch_decode_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  t_fetch_entry  wdata,
    input  logic [AW-1:0] raddr,
    output t_fetch_entry  rdata
);

    t_fetch_entry mem [DEPTH];

    // Clear wins over write; otherwise store the pushed entry
    always_ff @(posedge clk) begin
        if (clr) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: elastic buffer between fetch and decode. In-order
// valid/ready queue with wrap-bit pointers, flushed on redirect.
// Optional macro FDQ_BYPASS_EN: when empty, forward the fetched word straight
// to decode in the same cycle (no write). Undefined: strict 1-cycle latency.
module fetch_decode_queue
    import fetch_decode_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    fetch_decode_queue_if.slave   bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          accept;
    logic          push;
    logic          pop;
    logic          bypass;
    t_fetch_entry  head;
    t_fetch_entry  wr_entry;

    logic               out_valid_c;
    t_xlen              out_pc_c;
    logic [INSTR_W-1:0] out_instr_c;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // Ready depends only on registered occupancy (and reset), never on out_ready,
    // so a pop at full cannot make room in the same cycle.
    assign accept = !full && !rst;

`ifdef FDQ_BYPASS_EN
    assign bypass = empty && bus.in_valid && bus.out_ready && !flush && !rst;
`else
    assign bypass = 1'b0;
`endif

    assign push = bus.in_valid && accept && !flush && !bypass;
    assign pop  = !empty && bus.out_ready && !flush && !rst;

    assign wr_entry = '{pc: bus.in_pc, instr: bus.in_instr};

    fdq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk   (clk),
        .clr   (rst),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_entry),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (head)
    );

    // Pointer update: reset/flush discard everything, including this cycle's push/pop
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Decode-side view: head entry, or forwarded input when empty and bypass is built in
    always_comb begin
        out_valid_c = 1'b0;
        out_pc_c    = '0;
        out_instr_c = '0;
        if (!rst) begin
            if (!empty) begin
                out_valid_c = 1'b1;
                out_pc_c    = head.pc;
                out_instr_c = head.instr;
            end else begin
`ifdef FDQ_BYPASS_EN
                out_valid_c = bus.in_valid && !flush;
                out_pc_c    = bus.in_pc;
                out_instr_c = bus.in_instr;
`else
                out_pc_c    = head.pc;
                out_instr_c = head.instr;
`endif
            end
        end
    end

    assign bus.in_ready       = accept;
    assign bus.out_valid      = out_valid_c;
    assign bus.out_pc         = out_pc_c;
    assign bus.out_instr      = out_instr_c;
    assign bus.out_misaligned = out_valid_c && pc_misaligned(out_pc_c);
    assign bus.count          = rst ? '0 : (wr_ptr - rd_ptr);

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue: directed scenarios followed by
// random traffic, compared each cycle against a queue-based reference model.
module tb_fetch_decode_queue;
    import fetch_decode_queue_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    int checks = 0;
    int errors = 0;

    t_fetch_entry exp_q[$];
    bit           fresh = 1'b1;

    fetch_decode_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_decode_queue #(
        .DEPTH (DEPTH)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare at the falling edge, advance the model at the rising edge
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [31:0] pc, input logic [31:0] instr, input logic ordy);
        int   sz;
        logic exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic acc;
        logic deq;
        logic byp;

        rst           = r;
        flush         = f;
        bus.in_valid  = iv;
        bus.in_pc     = pc;
        bus.in_instr  = instr;
        bus.out_ready = ordy;

        @(negedge clk);
        sz        = exp_q.size();
        exp_valid = 1'b0;
        exp_pc    = '0;
        exp_instr = '0;
        if (!r) begin
            if (sz > 0) begin
                exp_valid = 1'b1;
                exp_pc    = exp_q[0].pc;
                exp_instr = exp_q[0].instr;
            end
`ifdef FDQ_BYPASS_EN
            else if (iv && !f) begin
                exp_valid = 1'b1;
                exp_pc    = pc;
                exp_instr = instr;
            end
`endif
        end

        check("in_ready", 64'(bus.in_ready), 64'(!r && sz < int'(DEPTH)));
        check("out_valid", 64'(bus.out_valid), 64'(exp_valid));
        check("count", 64'(bus.count), r ? 64'd0 : 64'(sz));
        if (exp_valid) begin
            check("out_pc", 64'(bus.out_pc), 64'(exp_pc));
            check("out_instr", 64'(bus.out_instr), 64'(exp_instr));
            check("out_misaligned", 64'(bus.out_misaligned), 64'(exp_pc[1:0] != 2'b00));
        end else begin
            check("out_misaligned_idle", 64'(bus.out_misaligned), 64'd0);
            if (r || fresh) begin
                check("out_pc_cleared", 64'(bus.out_pc), 64'd0);
                check("out_instr_cleared", 64'(bus.out_instr), 64'd0);
            end
        end

        @(posedge clk);
        if (r || f) begin
            exp_q.delete();
            if (r) fresh = 1'b1;
        end else begin
            acc = iv && (sz < int'(DEPTH));
            deq = (sz > 0) && ordy;
            byp = 1'b0;
`ifdef FDQ_BYPASS_EN
            byp = (sz == 0) && iv && ordy;
`endif
            if (deq) void'(exp_q.pop_front());
            if (acc && !byp) begin
                exp_q.push_back('{pc: pc, instr: instr});
                fresh = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        logic [31:0] rpc;

        // Reset
        step(1, 0, 0, 32'h0, 32'h0, 0);
        step(1, 0, 1, 32'h44, 32'h55, 1);

        // In-order capture while stalled, then drain
        step(0, 0, 1, 32'h0, 32'h0000_0013, 0);
        step(0, 0, 1, 32'h4, 32'h0010_0093, 0);
        step(0, 0, 1, 32'h8, 32'h0020_0113, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, 32'h0, 1);

        // Fill to DEPTH, hold a 5th word until a pop has made room
        for (int i = 0; i < 4; i++) step(0, 0, 1, 32'(i * 4), $urandom, 0);
        step(0, 0, 1, 32'h10, 32'hABCD_0010, 0);
        step(0, 0, 1, 32'h10, 32'hABCD_0010, 0);
        step(0, 0, 1, 32'h10, 32'hABCD_0010, 1);
        step(0, 0, 1, 32'h10, 32'hABCD_0010, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 32'h0, 32'h0, 1);

        // Streaming through the wrap point twice
        for (int i = 0; i < 10; i++) step(0, 0, 1, 32'(i * 4), $urandom, 1);
        step(0, 0, 0, 32'h0, 32'h0, 1);

        // Flush beats a concurrent push and pop
        for (int i = 0; i < 3; i++) step(0, 0, 1, 32'(32'h20 + i * 4), $urandom, 0);
        step(0, 1, 1, 32'h40, 32'h0000_0040, 1);
        step(0, 0, 0, 32'h0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 32'h0, 1);

        // Misaligned head flag
        step(0, 0, 1, 32'h102, 32'h1111_1111, 0);
        step(0, 0, 1, 32'h104, 32'h2222_2222, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 32'h0, 1);

        // Empty queue with fetch and decode both ready
        step(0, 0, 1, 32'h80, 32'h0000_0080, 1);
        step(0, 0, 0, 32'h0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 32'h0, 1);

        // Reset mid-operation, next word lands at index 0
        step(0, 0, 1, 32'h200, $urandom, 0);
        step(0, 0, 1, 32'h204, $urandom, 0);
        step(1, 0, 1, 32'h208, $urandom, 1);
        step(0, 0, 0, 32'h0, 32'h0, 0);
        step(0, 0, 1, 32'h300, 32'h3300_0000, 0);
        step(0, 0, 0, 32'h0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 32'h0, 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rpc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 3) != 0), rpc, $urandom,
                 ($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
